load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_if.sv | 28 ++
 rtl/load_store_unit.sv | 137 +++++++++++++
 tb/tb_load_store_unit.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// CPU request/response and data-memory port bundle for load_store_unit.
// slave = the LSU side; master = the CPU plus memory side that drives it.
interface load_store_unit_if;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic        done;
    logic [31:0] rdata;
    logic        err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_wen;
    logic [31:0] mem_rdata;

    modport slave (
        input  req, we, size, sign_ext, addr, wdata, mem_rdata,
        output ready, done, rdata, err, mem_addr, mem_wdata, mem_wen
    );

    modport master (
        output req, we, size, sign_ext, addr, wdata, mem_rdata,
        input  ready, done, rdata, err, mem_addr, mem_wdata, mem_wen
    );
endinterface

// File: rtl/load_store_unit.sv
// Byte/halfword/word load-store unit in front of a word-wide memory with a
// one-cycle registered read port; sub-word stores use read-modify-write.
module load_store_unit #(
    parameter int MEM_WORDS = 1024
) (
    input  logic               clk,
    input  logic               reset,
    load_store_unit_if.slave   bus
);
    localparam logic [31:0] MEM_WORDS_W = 32'(MEM_WORDS);

    typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT, S_WRITE, S_DONE} state_t;

    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic        sign_ext;
        logic [31:0] addr;
        logic [31:0] wdata;
    } lsu_req_t;

    state_t          state_q, state_d;
    lsu_req_t        req_q, req_d;
    logic            ready_q, ready_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic            mem_wen_q, mem_wen_d;
    logic [31:0]     rdata_q, rdata_d;
    logic [3:0][7:0] mem_wdata_q, mem_wdata_d;

    logic            bad_req;
    logic [3:0][7:0] rd_lanes, merged;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [31:0]     ld_data;

    always_comb begin
        bad_req = 1'b0;
        case (bus.size)
            2'b00:   bad_req = 1'b0;
            2'b01:   bad_req = bus.addr[0];
            2'b10:   bad_req = |bus.addr[1:0];
            default: bad_req = 1'b1;
        endcase
        if ({2'b00, bus.addr[31:2]} >= MEM_WORDS_W) bad_req = 1'b1;
    end

    // Little-endian lane select for loads and lane replace for sub-word stores.
    always_comb begin
        rd_lanes = bus.mem_rdata;
        ld_byte  = rd_lanes[req_q.addr[1:0]];
        ld_half  = req_q.addr[1] ? {rd_lanes[3], rd_lanes[2]} : {rd_lanes[1], rd_lanes[0]};
        case (req_q.size)
            2'b00:   ld_data = {{24{req_q.sign_ext & ld_byte[7]}}, ld_byte};
            2'b01:   ld_data = {{16{req_q.sign_ext & ld_half[15]}}, ld_half};
            default: ld_data = bus.mem_rdata;
        endcase
        merged = rd_lanes;
        case (req_q.size)
            2'b00:   merged[req_q.addr[1:0]] = req_q.wdata[7:0];
            2'b01:   if (req_q.addr[1]) merged[3:2] = req_q.wdata[15:0];
                     else               merged[1:0] = req_q.wdata[15:0];
            default: merged = req_q.wdata;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        rdata_d     = rdata_q;
        mem_wdata_d = mem_wdata_q;
        err_d       = 1'b0;
        case (state_q)
            S_IDLE: if (bus.req) begin
                req_d.we       = bus.we;
                req_d.size     = bus.size;
                req_d.sign_ext = bus.sign_ext;
                req_d.addr     = bus.addr;
                req_d.wdata    = bus.wdata;
                if (bad_req) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                end else if (bus.we && bus.size == 2'b10) begin
                    state_d     = S_WRITE;
                    mem_wdata_d = bus.wdata;
                end else begin
                    state_d = S_READ;
                end
            end
            S_READ:  state_d = S_WAIT;
            S_WAIT: if (req_q.we) begin
                mem_wdata_d = merged;
                state_d     = S_WRITE;
            end else begin
                rdata_d = ld_data;
                state_d = S_DONE;
            end
            S_WRITE: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        ready_d   = (state_d == S_IDLE);
        done_d    = (state_d == S_DONE);
        mem_wen_d = (state_d == S_WRITE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            req_q       <= '0;
            ready_q     <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            mem_wen_q   <= 1'b0;
            rdata_q     <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            ready_q     <= ready_d;
            done_q      <= done_d;
            err_q       <= err_d;
            mem_wen_q   <= mem_wen_d;
            rdata_q     <= rdata_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign bus.ready     = ready_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.rdata     = rdata_q;
    assign bus.mem_addr  = {2'b00, req_q.addr[31:2]};
    assign bus.mem_wdata = mem_wdata_q;
    // Masked by reset so a reset landing in WRITE cannot commit the store.
    assign bus.mem_wen   = mem_wen_q & reset;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit against a registered-read word memory model.
module tb_load_store_unit;
    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    load_store_unit_if bus();

    load_store_unit #(.MEM_WORDS(1024)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    logic [31:0] mem [0:1023];
    logic        bd_we = 1'b0;
    logic [9:0]  bd_idx;
    logic [31:0] bd_data;

    always @(posedge clk) begin
        if (bus.mem_wen) mem[bus.mem_addr[9:0]] <= bus.mem_wdata;
        if (bd_we) mem[bd_idx] <= bd_data;
        bus.mem_rdata <= mem[bus.mem_addr[9:0]];
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [9:0] idx, input logic [31:0] data);
        bd_we = 1'b1; bd_idx = idx; bd_data = data;
        tick;
        bd_we = 1'b0;
    endtask

    // Issues one request from IDLE and follows it to done (lat=-1 if none within 10 cycles).
    task automatic run_op(input logic we, input logic [1:0] size, input logic sx,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output int lat, output int nwen, output logic [31:0] wa,
                          output logic [31:0] wd, output logic [31:0] rd, output logic e);
        bus.req = 1'b1; bus.we = we; bus.size = size; bus.sign_ext = sx;
        bus.addr = addr; bus.wdata = wdata;
        tick;
        bus.req = 1'b0;
        lat = -1; nwen = 0; wa = 'x; wd = 'x; rd = 'x; e = 1'bx;
        for (int c = 1; c <= 10; c++) begin
            if (bus.mem_wen) begin
                nwen++; wa = bus.mem_addr; wd = bus.mem_wdata;
            end
            if (bus.done) begin
                lat = c; rd = bus.rdata; e = bus.err;
                break;
            end
            tick;
        end
        tick;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        bus.req = 1'b1; bus.we = 1'b1; bus.size = 2'b10; bus.sign_ext = 1'b0;
        bus.addr = 32'h10; bus.wdata = 32'h5A5A5A5A;
        tick; tick;
        n_tests++; if (bus.ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready got %b exp 1", bus.ready); end
        n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL rst_done got %b exp 0", bus.done); end
        n_tests++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL rst_err got %b exp 0", bus.err); end
        n_tests++; if (bus.rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata got %h exp 0", bus.rdata); end
        n_tests++; if (bus.mem_wen !== 1'b0) begin n_fail++; $display("FAIL rst_mem_wen got %b exp 0", bus.mem_wen); end
        n_tests++; if (bus.mem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_mem_addr got %h exp 0", bus.mem_addr); end
        n_tests++; if (bus.mem_wdata !== 32'h0) begin n_fail++; $display("FAIL rst_mem_wdata got %h exp 0", bus.mem_wdata); end
        bus.req = 1'b0;
        reset = 1'b1;
        tick;
        n_tests++; if (bus.ready !== 1'b1 || bus.done !== 1'b0) begin n_fail++; $display("FAIL rst_req_ignored ready=%b done=%b exp 1/0", bus.ready, bus.done); end
    endtask

    task automatic test_word_store;
        int lat, nwen; logic [31:0] wa, wd, rd; logic e;
        preload(10'd4, 32'h0);
        run_op(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, lat, nwen, wa, wd, rd, e);
        n_tests++; if (lat !== 2) begin n_fail++; $display("FAIL wst_lat got %0d exp 2", lat); end
        n_tests++; if (nwen !== 1) begin n_fail++; $display("FAIL wst_nwen got %0d exp 1", nwen); end
        n_tests++; if (wa !== 32'd4) begin n_fail++; $display("FAIL wst_mem_addr got %h exp 4", wa); end
        n_tests++; if (wd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wst_mem_wdata got %h exp deadbeef", wd); end
        n_tests++; if (e !== 1'b0) begin n_fail++; $display("FAIL wst_err got %b exp 0", e); end
        n_tests++; if (mem[4] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wst_mem got %h exp deadbeef", mem[4]); end
    endtask

    task automatic test_byte_store_load;
        int lat, nwen; logic [31:0] wa, wd, rd; logic e;
        preload(10'd4, 32'h11223344);
        run_op(1'b1, 2'b00, 1'b0, 32'h12, 32'h123456AB, lat, nwen, wa, wd, rd, e);
        n_tests++; if (lat !== 4) begin n_fail++; $display("FAIL bst_lat got %0d exp 4", lat); end
        n_tests++; if (nwen !== 1) begin n_fail++; $display("FAIL bst_nwen got %0d exp 1", nwen); end
        n_tests++; if (wd !== 32'h11AB3344) begin n_fail++; $display("FAIL bst_merge got %h exp 11ab3344", wd); end
        n_tests++; if (mem[4] !== 32'h11AB3344) begin n_fail++; $display("FAIL bst_mem got %h exp 11ab3344", mem[4]); end
        run_op(1'b0, 2'b00, 1'b1, 32'h12, 32'h0, lat, nwen, wa, wd, rd, e);
        n_tests++; if (lat !== 3) begin n_fail++; $display("FAIL bld_lat got %0d exp 3", lat); end
        n_tests++; if (rd !== 32'hFFFFFFAB) begin n_fail++; $display("FAIL bld_signed got %h exp ffffffab", rd); end
        n_tests++; if (nwen !== 0 || e !== 1'b0) begin n_fail++; $display("FAIL bld_wen_err got %0d/%b exp 0/0", nwen, e); end
        run_op(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, lat, nwen, wa, wd, rd, e);
        n_tests++; if (rd !== 32'h00000011) begin n_fail++; $display("FAIL bld_unsigned got %h exp 00000011", rd); end
    endtask

    task automatic test_halfword;
        int lat, nwen; logic [31:0] wa, wd, rd; logic e;
        preload(10'd4, 32'h8001FFFE);
        run_op(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, lat, nwen, wa, wd, rd, e);
        n_tests++; if (rd !== 32'h00008001 || lat !== 3) begin n_fail++; $display("FAIL hld_hi_zx got %h lat %0d exp 00008001 lat 3", rd, lat); end
        run_op(1'b0, 2'b01, 1'b1, 32'h10, 32'h0, lat, nwen, wa, wd, rd, e);
        n_tests++; if (rd !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL hld_lo_sx got %h exp fffffffe", rd); end
        run_op(1'b0, 2'b10, 1'b1, 32'h10, 32'h0, lat, nwen, wa, wd, rd, e);
        n_tests++; if (rd !== 32'h8001FFFE) begin n_fail++; $display("FAIL wld_ignore_sx got %h exp 8001fffe", rd); end
        run_op(1'b1, 2'b01, 1'b0, 32'h12, 32'hABCD5555, lat, nwen, wa, wd, rd, e);
        n_tests++; if (mem[4] !== 32'h5555FFFE || lat !== 4) begin n_fail++; $display("FAIL hst_merge got %h lat %0d exp 5555fffe lat 4", mem[4], lat); end
    endtask

    task automatic test_errors;
        int lat, nwen; logic [31:0] wa, wd, rd; logic e;
        preload(10'd4, 32'hCAFEF00D);
        preload(10'd1023, 32'h01234567);
        run_op(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, nwen, wa, wd, rd, e);
        n_tests++; if (rd !== 32'hCAFEF00D) begin n_fail++; $display("FAIL err_setup_load got %h exp cafef00d", rd); end
        run_op(1'b0, 2'b10, 1'b0, 32'h11, 32'h0, lat, nwen, wa, wd, rd, e);
        n_tests++; if (lat !== 1 || e !== 1'b1 || nwen !== 0 || rd !== 32'hCAFEF00D) begin n_fail++; $display("FAIL err_word_misalign lat %0d err %b wen %0d rd %h exp 1/1/0/cafef00d", lat, e, nwen, rd); end
        run_op(1'b1, 2'b01, 1'b0, 32'h13, 32'h1111, lat, nwen, wa, wd, rd, e);
        n_tests++; if (lat !== 1 || e !== 1'b1 || nwen !== 0 || rd !== 32'hCAFEF00D) begin n_fail++; $display("FAIL err_half_misalign lat %0d err %b wen %0d rd %h exp 1/1/0/cafef00d", lat, e, nwen, rd); end
        n_tests++; if (mem[4] !== 32'hCAFEF00D) begin n_fail++; $display("FAIL err_mem_untouched got %h exp cafef00d", mem[4]); end
        run_op(1'b0, 2'b10, 1'b0, 32'h1000, 32'h0, lat, nwen, wa, wd, rd, e);
        n_tests++; if (lat !== 1 || e !== 1'b1 || nwen !== 0 || rd !== 32'hCAFEF00D) begin n_fail++; $display("FAIL err_range lat %0d err %b wen %0d rd %h exp 1/1/0/cafef00d", lat, e, nwen, rd); end
        run_op(1'b1, 2'b11, 1'b0, 32'h10, 32'h0, lat, nwen, wa, wd, rd, e);
        n_tests++; if (lat !== 1 || e !== 1'b1 || nwen !== 0) begin n_fail++; $display("FAIL err_size11 lat %0d err %b wen %0d exp 1/1/0", lat, e, nwen); end
        run_op(1'b0, 2'b10, 1'b0, 32'hFFC, 32'h0, lat, nwen, wa, wd, rd, e);
        n_tests++; if (lat !== 3 || e !== 1'b0 || rd !== 32'h01234567) begin n_fail++; $display("FAIL last_word lat %0d err %b rd %h exp 3/0/01234567", lat, e, rd); end
    endtask

    task automatic test_reset_in_write;
        int ndone = 0;
        preload(10'd4, 32'h11223344);
        bus.req = 1'b1; bus.we = 1'b1; bus.size = 2'b00; bus.sign_ext = 1'b0;
        bus.addr = 32'h10; bus.wdata = 32'h000000EE;
        tick;
        bus.req = 1'b0;
        tick; tick;
        n_tests++; if (bus.mem_wen !== 1'b1) begin n_fail++; $display("FAIL rw_in_write got mem_wen %b exp 1", bus.mem_wen); end
        reset = 1'b0;
        #1;
        n_tests++; if (bus.mem_wen !== 1'b0) begin n_fail++; $display("FAIL rw_wen_masked got %b exp 0", bus.mem_wen); end
        tick;
        if (bus.done) ndone++;
        n_tests++; if (bus.ready !== 1'b1 || bus.mem_wen !== 1'b0) begin n_fail++; $display("FAIL rw_after ready %b wen %b exp 1/0", bus.ready, bus.mem_wen); end
        reset = 1'b1;
        tick;
        if (bus.done) ndone++;
        tick;
        if (bus.done) ndone++;
        n_tests++; if (ndone !== 0) begin n_fail++; $display("FAIL rw_no_done got %0d exp 0", ndone); end
        n_tests++; if (mem[4] !== 32'h11223344) begin n_fail++; $display("FAIL rw_mem got %h exp 11223344", mem[4]); end
    endtask

    task automatic test_back_to_back;
        int acc = 0, dn = 0, nwen = 0, badrd = 0;
        preload(10'd5, 32'h0A0B0C0D);
        bus.req = 1'b1; bus.we = 1'b0; bus.size = 2'b10; bus.sign_ext = 1'b0;
        bus.addr = 32'h14; bus.wdata = 32'h0;
        for (int i = 0; i < 20; i++) begin
            if (bus.ready) acc++;
            tick;
            if (bus.done) begin
                dn++;
                if (bus.rdata !== 32'h0A0B0C0D) badrd++;
            end
        end
        bus.req = 1'b0;
        n_tests++; if (acc !== 5 || dn !== 5) begin n_fail++; $display("FAIL b2b_load acc %0d done %0d exp 5/5", acc, dn); end
        n_tests++; if (badrd !== 0) begin n_fail++; $display("FAIL b2b_load_rdata bad %0d exp 0", badrd); end
        acc = 0; dn = 0;
        bus.req = 1'b1; bus.we = 1'b1; bus.addr = 32'h18; bus.wdata = 32'h600DF00D;
        for (int i = 0; i < 12; i++) begin
            if (bus.ready) acc++;
            tick;
            if (bus.done) dn++;
            if (bus.mem_wen) nwen++;
        end
        bus.req = 1'b0;
        tick;
        n_tests++; if (acc !== 4 || dn !== 4 || nwen !== 4) begin n_fail++; $display("FAIL b2b_store acc %0d done %0d wen %0d exp 4/4/4", acc, dn, nwen); end
        n_tests++; if (mem[6] !== 32'h600DF00D) begin n_fail++; $display("FAIL b2b_store_mem got %h exp 600df00d", mem[6]); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.req = 1'b0; bus.we = 1'b0; bus.size = 2'b00; bus.sign_ext = 1'b0;
        bus.addr = '0; bus.wdata = '0;
        reset = 1'b0;
        #1;
        test_reset;
        test_word_store;
        test_byte_store_load;
        test_halfword;
        test_errors;
        test_reset_in_write;
        test_back_to_back;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
